// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data,
// aligns/extends it and drives the register-file write port.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [4:0]       mem_rd,
   input  logic             mem_wer,
   input  logic [1:0]       mem_wbsel,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_pc4,
   input  logic [2:0]       mem_funct3,
   input  logic [1:0]       mem_addr_lo,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  regdata,
   output logic             wer,
   output logic             wb_stall,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READY   = 2'd1,
      WAIT_LD = 2'd2
   } state_t;

   localparam logic [1:0] WBSEL_LOAD = 2'b01;
   localparam logic [1:0] WBSEL_PC4  = 2'b10;

   state_t            state_reg, state_next;
   logic [XLEN-1:0]   result_reg, result_next;
   logic [4:0]        rd_reg;
   logic              wer_reg;
   logic [2:0]        funct3_reg;
   logic [1:0]        addr_lo_reg;
   logic [CNT_W-1:0]  instret_reg;
   logic              accept;

   logic [7:0]        byte_lane [4];
   logic [15:0]       half_lane [2];
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [XLEN-1:0]   load_value;

   // Split the raw load word into its byte and halfword lanes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = dmem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = dmem_rdata[16*gi +: 16];
      end
   endgenerate

   // Select and extend the load value using the latched funct3/address bits;
   // addr_lo[0] is irrelevant for halfwords since misalignment traps earlier.
   always_comb begin
      sel_byte   = byte_lane[addr_lo_reg];
      sel_half   = half_lane[addr_lo_reg[1]];
      load_value = dmem_rdata;
      case (funct3_reg)
         3'b000:  load_value = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         3'b100:  load_value = {{(XLEN-8){1'b0}}, sel_byte};
         3'b001:  load_value = {{(XLEN-16){sel_half[15]}}, sel_half};
         3'b101:  load_value = {{(XLEN-16){1'b0}}, sel_half};
         default: load_value = dmem_rdata;
      endcase
   end

   // Next-state and result selection; rvalid only matters in WAIT_LD and
   // mem_valid is only honoured outside it.
   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      accept      = 1'b0;
      case (state_reg)
         IDLE, READY: begin
            if (mem_valid) begin
               accept = 1'b1;
               if (mem_wbsel == WBSEL_LOAD) begin
                  state_next = WAIT_LD;
               end else begin
                  state_next  = READY;
                  result_next = (mem_wbsel == WBSEL_PC4) ? mem_pc4 : mem_alu_result;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT_LD: begin
            if (dmem_rvalid) begin
               state_next  = READY;
               result_next = load_value;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
      end
   end

   // Capture the instruction fields when it is accepted from MEM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_reg      <= '0;
         wer_reg     <= 1'b0;
         funct3_reg  <= '0;
         addr_lo_reg <= '0;
      end else if (accept) begin
         rd_reg      <= mem_rd;
         wer_reg     <= mem_wer;
         funct3_reg  <= mem_funct3;
         addr_lo_reg <= mem_addr_lo;
      end
   end

   // Every READY cycle retires one instruction, whether or not it writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_reg <= '0;
      end else if (state_reg == READY) begin
         instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign mem_ready = (state_reg != WAIT_LD);
   assign wb_stall  = (state_reg == WAIT_LD);
   assign wer       = (state_reg == READY) && wer_reg && (rd_reg != 5'd0);
   assign rd        = rd_reg;
   assign regdata   = result_reg;
   assign instret   = instret_reg;

endmodule
